// File: rtl/wide_mult_axi_legup_div_pkg.sv
// Shared types, representation names and the counter-width helper for the legup divider.
package wide_mult_axi_legup_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam string REP_SIGNED   = "SIGNED";
  localparam string REP_UNSIGNED = "UNSIGNED";

  // Ceiling log2, never below 1 so the step counter always has at least one bit.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wide_mult_axi_legup_div_if.sv
// Operand and result valid/ready channels of the legup divider.
// The dbz flag is present only when LEGUP_DIV_DBZ_FLAG_EN is defined.
interface wide_mult_axi_legup_div_if #(
  parameter int widthn = 32,
  parameter int widthd = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [widthn-1:0] numer;
  logic [widthd-1:0] denom;
  logic              out_valid;
  logic              out_ready;
  logic [widthn-1:0] quotient;
  logic [widthd-1:0] remain;
`ifdef LEGUP_DIV_DBZ_FLAG_EN
  logic              dbz;
`endif

  modport slave (
    input  in_valid, numer, denom, out_ready,
`ifdef LEGUP_DIV_DBZ_FLAG_EN
    output dbz,
`endif
    output in_ready, out_valid, quotient, remain
  );

  modport master (
    output in_valid, numer, denom, out_ready,
`ifdef LEGUP_DIV_DBZ_FLAG_EN
    input  dbz,
`endif
    input  in_ready, out_valid, quotient, remain
  );

endinterface

// File: rtl/wide_mult_axi_legup_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module wide_mult_axi_legup_div_step #(
  parameter int widthd = 32
) (
  input  logic [widthd-1:0] r,
  input  logic [widthd-1:0] d,
  input  logic              nbit,
  output logic [widthd-1:0] r_next,
  output logic              qbit
);

  logic [widthd:0] shifted;

  assign shifted = {r, nbit};
  assign qbit    = (shifted >= {1'b0, d});
  // The true difference is below d, so the low widthd bits hold it exactly.
  assign r_next  = qbit ? (shifted[widthd-1:0] - d) : shifted[widthd-1:0];

endmodule

// File: rtl/wide_mult_axi_legup_div.sv
// Iterative radix-2 restoring divider with valid/ready operand and result channels.
// Optional dbz result flag enabled by defining LEGUP_DIV_DBZ_FLAG_EN.
module wide_mult_axi_legup_div
  import wide_mult_axi_legup_div_pkg::*;
#(
  parameter int    widthn         = 32,
  parameter int    widthd         = 32,
  parameter string representation = "UNSIGNED"
) (
  input logic                       clock,
  input logic                       reset,
  input logic                       clken,
  wide_mult_axi_legup_div_if.slave  bus
);

  localparam bit              is_signed = (representation == REP_SIGNED);
  localparam int              cntw      = clog2(widthn);
  localparam logic [cntw-1:0] last_cnt  = cntw'(widthn - 1);

  state_t            state;
  state_t            state_nx;
  logic [cntw-1:0]   cnt;
  logic [widthn-1:0] nreg;
  logic [widthd-1:0] dreg;
  logic [widthd-1:0] rreg;
  logic [widthd-1:0] nlow;
  logic              negq;
  logic              negr;
  logic              dbz_r;
  logic [widthn-1:0] quotient_r;
  logic [widthd-1:0] remain_r;
  logic              dbz_out;
  logic              accept;
  logic [widthd-1:0] r_next;
  logic              qbit;
  logic [widthn-1:0] q_fix;
  logic [widthd-1:0] r_fix;

  logic signed [widthn-1:0] numer_s;
  logic signed [widthd-1:0] denom_s;

  assign numer_s = bus.numer;
  assign denom_s = bus.denom;

  function automatic logic [widthn-1:0] mag_n(input logic signed [widthn-1:0] v);
    logic [widthn-1:0] u;
    u = v;
    return (is_signed && (v < 0)) ? -u : u;
  endfunction

  function automatic logic [widthd-1:0] mag_d(input logic signed [widthd-1:0] v);
    logic [widthd-1:0] u;
    u = v;
    return (is_signed && (v < 0)) ? -u : u;
  endfunction

  assign bus.in_ready  = (state == IDLE) && clken;
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remain    = remain_r;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef LEGUP_DIV_DBZ_FLAG_EN
  assign bus.dbz = dbz_out;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_out;
`endif

  wide_mult_axi_legup_div_step #(
    .widthd (widthd)
  ) u_step (
    .r      (rreg),
    .d      (dreg),
    .nbit   (nreg[widthn-1]),
    .r_next (r_next),
    .qbit   (qbit)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // MIN / -1 needs no override: magnitude 2^(widthn-1) negates back to MIN with remainder 0.
  always_comb begin
    q_fix = negq ? -nreg : nreg;
    r_fix = negr ? -rreg : rreg;
    if (dbz_r) begin
      q_fix = '1;
      r_fix = nlow;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      quotient_r <= '0;
      remain_r   <= '0;
      dbz_out    <= 1'b0;
    end else if (clken) begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) cnt <= last_cnt;
        BUSY: if (cnt != '0) cnt <= cnt - cntw'(1);
        FIX: begin
          quotient_r <= q_fix;
          remain_r   <= r_fix;
          dbz_out    <= dbz_r;
        end
        default: ;
      endcase
    end
  end

  // Operand capture and iteration datapath; nreg shifts the dividend out and the quotient in.
  always_ff @(posedge clock) begin
    if (clken) begin
      if (accept) begin
        nreg  <= mag_n(numer_s);
        dreg  <= mag_d(denom_s);
        rreg  <= '0;
        nlow  <= bus.numer[widthd-1:0];
        negq  <= is_signed && ((numer_s < 0) != (denom_s < 0));
        negr  <= is_signed && (numer_s < 0);
        dbz_r <= (bus.denom == '0);
      end else if (state == BUSY) begin
        rreg <= r_next;
        nreg <= {nreg[widthn-2:0], qbit};
      end
    end
  end

endmodule

// File: tb/tb_wide_mult_axi_legup_div.sv
// Directed self-checking bench: unsigned and signed divider instances driven in lockstep.
module tb_wide_mult_axi_legup_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] numer = '0;
  logic [31:0] denom = '0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  wide_mult_axi_legup_div_if #(.widthn(32), .widthd(32)) if_u ();
  wide_mult_axi_legup_div_if #(.widthn(32), .widthd(32)) if_s ();

  assign if_u.in_valid  = in_valid;
  assign if_u.numer     = numer;
  assign if_u.denom     = denom;
  assign if_u.out_ready = out_ready;
  assign if_s.in_valid  = in_valid;
  assign if_s.numer     = numer;
  assign if_s.denom     = denom;
  assign if_s.out_ready = out_ready;

  wide_mult_axi_legup_div #(.widthn(32), .widthd(32), .representation("UNSIGNED")) u_uns (
    .clock (clock),
    .reset (reset),
    .clken (clken),
    .bus   (if_u.slave)
  );

  wide_mult_axi_legup_div #(.widthn(32), .widthd(32), .representation("SIGNED")) u_sig (
    .clock (clock),
    .reset (reset),
    .clken (clken),
    .bus   (if_s.slave)
  );

  task automatic send(input logic [31:0] n, input logic [31:0] d);
    int t;
    t = 0;
    @(negedge clock);
    numer    = n;
    denom    = d;
    in_valid = 1'b1;
    while (!if_u.in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (if_u.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required=1", if_u.in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!if_u.out_valid && cyc < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (if_u.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_u: got %b want 0", if_u.out_valid); end
    checks++; if (if_s.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_s: got %b want 0", if_s.out_valid); end
    checks++; if (if_u.quotient !== 32'h0) begin errors++; $display("FAIL rst_quot: got %h want 0", if_u.quotient); end
    checks++; if (if_u.remain !== 32'h0) begin errors++; $display("FAIL rst_rem: got %h want 0", if_u.remain); end
`ifdef LEGUP_DIV_DBZ_FLAG_EN
    checks++; if (if_u.dbz !== 1'b0) begin errors++; $display("FAIL rst_dbz: got %b want 0", if_u.dbz); end
`endif
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (if_u.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", if_u.in_ready); end
  endtask

  task automatic test_unsigned();
    int cyc;
    send(32'd100, 32'd7);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL uns_latency: got %0d want 33", cyc); end
    checks++; if (if_u.quotient !== 32'd14) begin errors++; $display("FAIL uns_quot: got %0d want 14", if_u.quotient); end
    checks++; if (if_u.remain !== 32'd2) begin errors++; $display("FAIL uns_rem: got %0d want 2", if_u.remain); end
    checks++; if (if_s.quotient !== 32'd14) begin errors++; $display("FAIL sig_pos_quot: got %0d want 14", if_s.quotient); end
    checks++; if (if_s.remain !== 32'd2) begin errors++; $display("FAIL sig_pos_rem: got %0d want 2", if_s.remain); end
`ifdef LEGUP_DIV_DBZ_FLAG_EN
    checks++; if (if_u.dbz !== 1'b0) begin errors++; $display("FAIL uns_dbz: got %b want 0", if_u.dbz); end
`endif
    @(posedge clock);
    #1;
    checks++; if (if_u.out_valid !== 1'b0) begin errors++; $display("FAIL uns_release: out_valid=%b want 0", if_u.out_valid); end
  endtask

  task automatic test_signed();
    logic [31:0] n [3];
    logic [31:0] d [3];
    logic [31:0] q [3];
    logic [31:0] r [3];
    int cyc;
    n[0] = 32'hFFFF_FF9C; d[0] = 32'd7;          q[0] = 32'hFFFF_FFF2; r[0] = 32'hFFFF_FFFE;
    n[1] = 32'd100;       d[1] = 32'hFFFF_FFF9;  q[1] = 32'hFFFF_FFF2; r[1] = 32'd2;
    n[2] = 32'h8000_0000; d[2] = 32'hFFFF_FFFF;  q[2] = 32'h8000_0000; r[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      send(n[i], d[i]);
      wait_result(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL sig_latency[%0d]: got %0d want 33", i, cyc); end
      checks++; if (if_s.quotient !== q[i]) begin errors++; $display("FAIL sig_quot[%0d]: got %h want %h", i, if_s.quotient, q[i]); end
      checks++; if (if_s.remain !== r[i]) begin errors++; $display("FAIL sig_rem[%0d]: got %h want %h", i, if_s.remain, r[i]); end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_dbz();
    int cyc;
    send(32'h1234, 32'h0);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL dbz_latency: got %0d want 33", cyc); end
    checks++; if (if_u.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quot_u: got %h want ffffffff", if_u.quotient); end
    checks++; if (if_u.remain !== 32'h1234) begin errors++; $display("FAIL dbz_rem_u: got %h want 1234", if_u.remain); end
    checks++; if (if_s.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quot_s: got %h want ffffffff", if_s.quotient); end
    checks++; if (if_s.remain !== 32'h1234) begin errors++; $display("FAIL dbz_rem_s: got %h want 1234", if_s.remain); end
`ifdef LEGUP_DIV_DBZ_FLAG_EN
    checks++; if (if_u.dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag_u: got %b want 1", if_u.dbz); end
    checks++; if (if_s.dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag_s: got %b want 1", if_s.dbz); end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_stall();
    int cyc;
    send(32'd1000, 32'd33);
    repeat (10) @(posedge clock);
    #1;
    clken    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (if_u.in_ready !== 1'b0 || if_u.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b want 0 0", i, if_u.in_ready, if_u.out_valid);
      end
    end
    in_valid = 1'b0;
    clken    = 1'b1;
    wait_result(cyc);
    checks++; if (cyc + 15 !== 38) begin errors++; $display("FAIL stall_latency: got %0d want 38", cyc + 15); end
    checks++; if (if_u.quotient !== 32'd30) begin errors++; $display("FAIL stall_quot: got %0d want 30", if_u.quotient); end
    checks++; if (if_u.remain !== 32'd10) begin errors++; $display("FAIL stall_rem: got %0d want 10", if_u.remain); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send(32'd1000, 32'd33);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL bp_latency: got %0d want 33", cyc); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (if_u.out_valid !== 1'b1 || if_u.quotient !== 32'd30 || if_u.remain !== 32'd10 || if_u.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b q=%0d r=%0d in_ready=%b want 1 30 10 0",
                 i, if_u.out_valid, if_u.quotient, if_u.remain, if_u.in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (if_u.out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: out_valid=%b want 0", if_u.out_valid); end
    checks++; if (if_u.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: in_ready=%b want 1", if_u.in_ready); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    send(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (if_u.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", if_u.out_valid); end
    checks++; if (if_u.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", if_u.in_ready); end
    checks++; if (if_u.quotient !== 32'h0) begin errors++; $display("FAIL rmid_quot: got %h want 0", if_u.quotient); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (if_u.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_output: valid cycles=%0d want 0", seen); end
    send(32'd9, 32'd3);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL rmid_latency: got %0d want 33", cyc); end
    checks++; if (if_u.quotient !== 32'd3) begin errors++; $display("FAIL rmid_quot2: got %0d want 3", if_u.quotient); end
    checks++; if (if_u.remain !== 32'd0) begin errors++; $display("FAIL rmid_rem2: got %0d want 0", if_u.remain); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
